// File: rtl/lcd_bus_pkg.sv
// Shared types and constants for the 8080-style panel write path.
// Entry layout is {dc, data}; dc selects command versus pixel/parameter data.
package lcd_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        LOW,
        HIGH
    } lcd_wr_state_t;

    localparam logic DC_CMD  = 1'b0;
    localparam logic DC_DATA = 1'b1;

    typedef struct packed {
        logic       dc;
        logic [7:0] data;
    } lcd_entry_t;

endpackage

// File: rtl/byte_fifo.sv
// Small synchronous FIFO with a combinational head; pointers wrap mod DEPTH.
// A push into a full FIFO is dropped even if a pop happens in the same cycle.
module byte_fifo #(
    parameter int W     = 9,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [W-1:0]             i_din,
    input  logic                     i_pop,
    output logic [W-1:0]             o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rp];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wp] <= i_din;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wp <= r_wp + AW'(1);
            end
            if (w_pop) begin
                r_rp <= r_rp + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/lcd_bus_writer.sv
// Drives the panel's write-only 8080 bus from a small byte FIFO.
// Each byte: one setup cycle, WR_LOW_CYC low, WR_HIGH_CYC high with bus held.
module lcd_bus_writer
    import lcd_bus_pkg::*;
#(
    parameter int WR_LOW_CYC  = 2,
    parameter int WR_HIGH_CYC = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       hwclk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic       in_dc,
    input  logic [7:0] in_byte,
    output logic       in_ready,
    output logic       dcx,
    output logic       wr,
    output logic [7:0] D,
    output logic       idle
);

    localparam int MAXC = (WR_LOW_CYC > WR_HIGH_CYC) ? WR_LOW_CYC : WR_HIGH_CYC;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] CNT_LOW  = CW'(WR_LOW_CYC - 1);
    localparam logic [CW-1:0] CNT_HIGH = CW'(WR_HIGH_CYC - 1);

    lcd_wr_state_t r_state;
    lcd_wr_state_t w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_wr;
    logic          r_dcx;
    logic [7:0]    r_d;
    logic          w_pop;
    lcd_entry_t    w_in;
    lcd_entry_t    w_head;
    logic          w_full;
    logic          w_empty;
    logic [$clog2(FIFO_DEPTH):0] w_count;

    assign w_in = '{dc: in_dc, data: in_byte};

    byte_fifo #(
        .W     ($bits(lcd_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (hwclk),
        .i_rst   (reset),
        .i_push  (in_valid),
        .i_din   (w_in),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge hwclk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pop       = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = LOAD;
                end
            end
            LOAD: begin
                w_state_nxt = LOW;
                w_cnt_nxt   = CNT_LOW;
            end
            LOW: begin
                if (r_cnt == '0) begin
                    w_state_nxt = HIGH;
                    w_cnt_nxt   = CNT_HIGH;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            HIGH: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end else if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = LOAD;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // wr is registered from the next state so the strobe never glitches.
    always_ff @(posedge hwclk) begin
        if (reset) begin
            r_cnt <= '0;
            r_wr  <= 1'b1;
            r_dcx <= DC_CMD;
            r_d   <= 8'h00;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_wr  <= (w_state_nxt != LOW);
            if (w_pop) begin
                r_dcx <= w_head.dc;
                r_d   <= w_head.data;
            end
        end
    end

    assign wr       = r_wr;
    assign dcx      = r_dcx;
    assign D        = r_d;
    assign in_ready = !w_full;
    assign idle     = (w_count == '0) && (r_state == IDLE);

endmodule

// File: tb/tb_lcd_bus_writer.sv
// Scoreboard bench for lcd_bus_writer at default timing parameters.
// Expected bytes are queued on acceptance and matched at each wr fall.
module tb_lcd_bus_writer;

    logic       hwclk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_dc = 1'b0;
    logic [7:0] in_byte = 8'h00;
    logic       in_ready;
    logic       dcx;
    logic       wr;
    logic [7:0] D;
    logic       idle;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int n_strobe = 0;
    int last_fall = -1;
    bit gap_en = 1'b0;
    bit saw_full = 1'b0;
    logic prev_wr = 1'b1;
    logic [8:0] held = '0;
    logic [8:0] sb[$];

    lcd_bus_writer dut (
        .hwclk    (hwclk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_dc    (in_dc),
        .in_byte  (in_byte),
        .in_ready (in_ready),
        .dcx      (dcx),
        .wr       (wr),
        .D        (D),
        .idle     (idle)
    );

    always #5 hwclk = ~hwclk;

    always @(posedge hwclk) cyc++;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    always @(negedge hwclk) begin
        if (!reset) begin
            if (in_valid && !in_ready) saw_full = 1'b1;
            if (prev_wr && !wr) begin
                n_strobe++;
                if (sb.size() == 0) begin
                    chk("sb_empty_at_strobe", 32'd1, 32'd0);
                end else begin
                    chk("bus_byte", {dcx, D}, sb.pop_front());
                end
                held = {dcx, D};
                if (gap_en && last_fall >= 0)
                    chk("strobe_gap", cyc - last_fall, 5);
                last_fall = cyc;
            end else if (!wr) begin
                chk("hold_while_low", {dcx, D}, held);
            end
        end
        prev_wr = wr;
    end

    // Called right after a negedge; returns right after the next negedge.
    task automatic send(input logic dc, input logic [7:0] b);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_dc    = dc;
        in_byte  = b;
        while (!in_ready && n < 100) begin
            @(negedge hwclk);
            n++;
        end
        if (n >= 100) chk("send_timeout", 32'd1, 32'd0);
        sb.push_back({dc, b});
        @(posedge hwclk);
        @(negedge hwclk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (!(idle && sb.size() == 0) && n < 200) begin
            @(negedge hwclk);
            n++;
        end
        chk(tag, idle, 1'b1);
    endtask

    logic exp_wr   [7] = '{1, 1, 0, 0, 1, 1, 1};
    logic exp_idle [7] = '{0, 0, 0, 0, 0, 0, 1};

    initial begin
        int s0;

        repeat (2) begin
            @(negedge hwclk);
            chk("rst_wr", wr, 1'b1);
            chk("rst_dcx", dcx, 1'b0);
            chk("rst_D", D, 8'h00);
            chk("rst_ready", in_ready, 1'b1);
            chk("rst_idle", idle, 1'b1);
        end
        reset = 1'b0;
        @(negedge hwclk);
        chk("post_rst_wr", wr, 1'b1);
        chk("post_rst_dcx", dcx, 1'b0);
        chk("post_rst_D", D, 8'h00);
        chk("post_rst_ready", in_ready, 1'b1);
        chk("post_rst_idle", idle, 1'b1);

        sb.push_back({1'b0, 8'h2A});
        in_valid = 1'b1;
        in_dc    = 1'b0;
        in_byte  = 8'h2A;
        @(posedge hwclk);
        @(negedge hwclk);
        in_valid = 1'b0;
        for (int j = 0; j < 7; j++) begin
            if (j > 0) @(negedge hwclk);
            chk($sformatf("single_wr_k%0d", j), wr, exp_wr[j]);
            chk($sformatf("single_idle_k%0d", j), idle, exp_idle[j]);
            if (j >= 1) begin
                chk($sformatf("single_D_k%0d", j), D, 8'h2A);
                chk($sformatf("single_dcx_k%0d", j), dcx, 1'b0);
            end
        end

        gap_en    = 1'b1;
        last_fall = -1;
        send(1'b0, 8'h2A);
        send(1'b1, 8'h3C);
        wait_idle("cmd_data_idle");
        chk("cmd_data_dcx", dcx, 1'b1);
        chk("cmd_data_D", D, 8'h3C);

        last_fall = -1;
        saw_full  = 1'b0;
        for (int i = 0; i < 6; i++) send(i[0], 8'h10 + 8'(i));
        chk("full_ready", in_ready, 1'b0);
        send(1'b1, 8'hFF);
        chk("stall_seen", saw_full, 1'b1);
        wait_idle("overflow_idle");
        chk("strobe_total", n_strobe, 10);
        gap_en = 1'b0;

        for (int i = 0; i < 4; i++) send(1'b1, 8'hA0 + 8'(i));
        begin
            int n;
            n = 0;
            while (wr && n < 50) begin
                @(negedge hwclk);
                n++;
            end
            chk("midlow_reached", wr, 1'b0);
        end
        reset = 1'b1;
        @(negedge hwclk);
        chk("midlow_wr", wr, 1'b1);
        chk("midlow_ready", in_ready, 1'b1);
        sb.delete();
        reset = 1'b0;
        @(negedge hwclk);
        chk("midlow_idle", idle, 1'b1);
        s0 = n_strobe;
        repeat (30) @(negedge hwclk);
        chk("midlow_no_strobe", n_strobe, s0);
        chk("midlow_wr_end", wr, 1'b1);
        chk("midlow_idle_end", idle, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
